// File: rtl/mod_counter_if.sv
// mod_counter_if -- control/data bundle for mod_counter.
//   CE    count enable                (master -> slave)
//   UP    direction, 1 = increment    (master -> slave)
//   LOAD  synchronous load strobe     (master -> slave)
//   D     load value                  (master -> slave)
//   O     registered count value      (slave -> master)
//   COUT  one-cycle wrap pulse        (slave -> master)
//   ZERO  registered O == 0 flag      (slave -> master)
interface mod_counter_if #(
  parameter int WIDTH = 22
) ();
  logic             CE;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] O;
  logic             COUT;
  logic             ZERO;

  modport master (
    output CE, UP, LOAD, D,
    input  O, COUT, ZERO
  );

  modport slave (
    input  CE, UP, LOAD, D,
    output O, COUT, ZERO
  );
endinterface

// File: rtl/mod_counter.sv
// mod_counter -- prescaled up/down modulo counter, range 0..MAX.
//   CLK    sole clock, rising edge
//   RESET  synchronous active-high reset
//   bus    mod_counter_if slave: CE, UP, LOAD, D in; O, COUT, ZERO out
// Parameters: WIDTH (1..32) count width, MAX (1..2**WIDTH-1) terminal
// count, DIV (1..2**16) enabled cycles per count step.
module mod_counter #(
  parameter int              WIDTH = 22,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter int              DIV   = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  mod_counter_if.slave bus
);

  localparam longint unsigned RANGE_TOP = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 1 || WIDTH > 32 || MAX > RANGE_TOP || MAX < 64'd1 ||
        DIV < 1 || DIV > 65536) begin : g_bad_params
      $error("mod_counter: illegal WIDTH/MAX/DIV combination");
    end
  endgenerate

  // Prescaler is wide enough for 0..DIV-1, but never narrower than 1 bit.
  localparam int               PS_W    = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(DIV - 1);

  logic [WIDTH-1:0] o_reg, o_next;
  logic [PS_W-1:0]  ps_reg, ps_next;
  logic             cout_reg, cout_next;
  logic             zero_reg, zero_next;
  logic             step;

  // With DIV=1 PS_LAST is 0 and PS stays at 0, so every enabled cycle steps.
  assign step = (ps_reg == PS_LAST);

  always_comb begin
    o_next    = o_reg;
    ps_next   = ps_reg;
    cout_next = 1'b0;

    if (bus.LOAD) begin
      // Out-of-range load values saturate so O never exceeds MAX.
      o_next  = (bus.D > MAX_V) ? MAX_V : bus.D;
      ps_next = '0;
    end else if (bus.CE) begin
      if (step) begin
        ps_next = '0;
        // UP only matters here; between steps it has no effect on PS.
        if (bus.UP) begin
          if (o_reg == MAX_V) begin
            o_next    = '0;
            cout_next = 1'b1;
          end else begin
            o_next = o_reg + WIDTH'(1);
          end
        end else begin
          if (o_reg == '0) begin
            o_next    = MAX_V;
            cout_next = 1'b1;
          end else begin
            o_next = o_reg - WIDTH'(1);
          end
        end
      end else begin
        ps_next = ps_reg + PS_W'(1);
      end
    end

    // Derived from the next count so the flag lands on the same edge as O.
    zero_next = (o_next == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_reg    <= '0;
      ps_reg   <= '0;
      cout_reg <= 1'b0;
      zero_reg <= 1'b1;
    end else begin
      o_reg    <= o_next;
      ps_reg   <= ps_next;
      cout_reg <= cout_next;
      zero_reg <= zero_next;
    end
  end

  assign bus.O    = o_reg;
  assign bus.COUT = cout_reg;
  assign bus.ZERO = zero_reg;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter -- directed self-checking bench for mod_counter.
//   dut_a: WIDTH=4, MAX=9, DIV=3
//   dut_b: WIDTH=4, MAX=9, DIV=1
//   dut_c: WIDTH=3, default MAX (7), default DIV (1)
module tb_mod_counter;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) bus_a ();
  mod_counter_if #(.WIDTH(4)) bus_b ();
  mod_counter_if #(.WIDTH(3)) bus_c ();

  mod_counter #(.WIDTH(4), .MAX(9), .DIV(3)) dut_a (
    .CLK(clk), .RESET(rst_a), .bus(bus_a)
  );
  mod_counter #(.WIDTH(4), .MAX(9), .DIV(1)) dut_b (
    .CLK(clk), .RESET(rst_b), .bus(bus_b)
  );
  mod_counter #(.WIDTH(3)) dut_c (
    .CLK(clk), .RESET(rst_c), .bus(bus_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One clock edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.CE = 0; bus_a.UP = 1; bus_a.LOAD = 0; bus_a.D = 0;
    bus_b.CE = 0; bus_b.UP = 1; bus_b.LOAD = 0; bus_b.D = 0;
    bus_c.CE = 0; bus_c.UP = 1; bus_c.LOAD = 0; bus_c.D = 0;

    // ---- dut_a: reset state ----
    rst_a = 1; bus_a.LOAD = 1; bus_a.D = 4'd7; bus_a.CE = 1;
    tick();
    chk("a_rst_O", 32'(bus_a.O), 0);
    chk("a_rst_COUT", 32'(bus_a.COUT), 0);
    chk("a_rst_ZERO", 32'(bus_a.ZERO), 1);

    // ---- dut_a: up count with DIV=3, 0..9,0 over 30 enabled cycles ----
    rst_a = 0; bus_a.LOAD = 0; bus_a.CE = 1; bus_a.UP = 1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("a_up_O_k%0d", k), 32'(bus_a.O), 32'((k / 3) % 10));
      chk($sformatf("a_up_COUT_k%0d", k), 32'(bus_a.COUT), (k == 30) ? 1 : 0);
      chk($sformatf("a_up_ZERO_k%0d", k), 32'(bus_a.ZERO), ((k / 3) % 10 == 0) ? 1 : 0);
    end

    // ---- dut_a: UP changes between steps do not disturb PS ----
    // PS is 0 and O is 0 here; steps land on the 3rd and 6th cycles.
    bus_a.UP = 0; tick(); chk("a_dir_O1", 32'(bus_a.O), 0);
    bus_a.UP = 0; tick(); chk("a_dir_O2", 32'(bus_a.O), 0);
    bus_a.UP = 1; tick(); chk("a_dir_O3", 32'(bus_a.O), 1);
    bus_a.UP = 1; tick(); chk("a_dir_O4", 32'(bus_a.O), 1);
    bus_a.UP = 1; tick(); chk("a_dir_O5", 32'(bus_a.O), 1);
    bus_a.UP = 0; tick(); chk("a_dir_O6", 32'(bus_a.O), 0);
    chk("a_dir_ZERO6", 32'(bus_a.ZERO), 1);
    chk("a_dir_COUT6", 32'(bus_a.COUT), 0);

    // ---- dut_a: load mid-prescale clears PS; CE pattern 1,0,1,0,1 ----
    rst_a = 1; tick(); rst_a = 0;
    bus_a.CE = 1; bus_a.UP = 1;
    tick(); tick();                          // PS = 2, O still 0
    chk("a_pre_O", 32'(bus_a.O), 0);
    bus_a.LOAD = 1; bus_a.D = 4'd5; tick(); bus_a.LOAD = 0;
    chk("a_ld_O", 32'(bus_a.O), 5);
    chk("a_ld_COUT", 32'(bus_a.COUT), 0);
    chk("a_ld_ZERO", 32'(bus_a.ZERO), 0);
    bus_a.CE = 1; tick(); chk("a_ce1_O", 32'(bus_a.O), 5);
    bus_a.CE = 0; tick(); chk("a_ce2_O", 32'(bus_a.O), 5);
    bus_a.CE = 1; tick(); chk("a_ce3_O", 32'(bus_a.O), 5);
    bus_a.CE = 0; tick(); chk("a_ce4_O", 32'(bus_a.O), 5);
    bus_a.CE = 1; tick(); chk("a_ce5_O", 32'(bus_a.O), 6);

    // ---- dut_a: reset at O=MAX with LOAD and CE asserted ----
    bus_a.LOAD = 1; bus_a.D = 4'd9; tick();
    chk("a_max_O", 32'(bus_a.O), 9);
    tick();                                  // advances PS by one more? no: LOAD holds PS at 0
    rst_a = 1; bus_a.LOAD = 1; bus_a.CE = 1; tick();
    chk("a_rl_O", 32'(bus_a.O), 0);
    chk("a_rl_COUT", 32'(bus_a.COUT), 0);
    chk("a_rl_ZERO", 32'(bus_a.ZERO), 1);
    rst_a = 0; bus_a.LOAD = 0; bus_a.UP = 1;
    tick(); chk("a_rel1_O", 32'(bus_a.O), 0);
    tick(); chk("a_rel2_O", 32'(bus_a.O), 0);
    tick(); chk("a_rel3_O", 32'(bus_a.O), 1);
    chk("a_rel3_ZERO", 32'(bus_a.ZERO), 0);

    // ---- dut_b: down count, DIV=1, sequence 9,8,...,0,9 ----
    rst_b = 1; tick(); rst_b = 0;
    chk("b_rst_O", 32'(bus_b.O), 0);
    chk("b_rst_ZERO", 32'(bus_b.ZERO), 1);
    bus_b.CE = 1; bus_b.UP = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("b_dn_O_k%0d", k), 32'(bus_b.O), 32'((10 - (k % 10)) % 10));
      chk($sformatf("b_dn_COUT_k%0d", k), 32'(bus_b.COUT), (k % 10 == 1) ? 1 : 0);
      chk($sformatf("b_dn_ZERO_k%0d", k), 32'(bus_b.ZERO), (k == 10) ? 1 : 0);
    end

    // CE low holds O and drops COUT.
    bus_b.CE = 0; tick();
    chk("b_hold_O", 32'(bus_b.O), 9);
    chk("b_hold_COUT", 32'(bus_b.COUT), 0);

    // Over-range load saturates to MAX, then one up step wraps.
    bus_b.CE = 1; bus_b.UP = 0; bus_b.LOAD = 1; bus_b.D = 4'd12; tick();
    chk("b_sat_O", 32'(bus_b.O), 9);
    chk("b_sat_COUT", 32'(bus_b.COUT), 0);
    bus_b.LOAD = 0; bus_b.UP = 1; tick();
    chk("b_wrap_O", 32'(bus_b.O), 0);
    chk("b_wrap_COUT", 32'(bus_b.COUT), 1);
    chk("b_wrap_ZERO", 32'(bus_b.ZERO), 1);
    tick();
    chk("b_after_O", 32'(bus_b.O), 1);
    chk("b_after_COUT", 32'(bus_b.COUT), 0);

    // Loading 0 raises ZERO on the same edge.
    bus_b.LOAD = 1; bus_b.D = 4'd0; tick(); bus_b.LOAD = 0;
    chk("b_ld0_O", 32'(bus_b.O), 0);
    chk("b_ld0_ZERO", 32'(bus_b.ZERO), 1);

    // ---- dut_c: default MAX = 2**3-1, full-range up wrap ----
    rst_c = 1; tick(); rst_c = 0;
    bus_c.CE = 1; bus_c.UP = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("c_up_O_k%0d", k), 32'(bus_c.O), 32'(k % 8));
      chk($sformatf("c_up_COUT_k%0d", k), 32'(bus_c.COUT), (k == 8) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter: WIDTH, 22, count register width in bits (1..32).
REQ-002 Parameter: MAX, 2**WIDTH-1, terminal count; the count range is 0..MAX.
REQ-003 Parameter: DIV, 1, prescale divisor; the count steps once per DIV enabled cycles (1..2**16).
REQ-004 Port: CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port: RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-006 Port: CE  input  1  count enable.
REQ-007 Port: UP  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 Port: LOAD  input  1  synchronous parallel load strobe.
REQ-009 Port: D  input  WIDTH  load value.
REQ-010 Port: O  output  WIDTH  registered count value.
REQ-011 Port: COUT  output  1  registered one-cycle wrap pulse.
REQ-012 Port: ZERO  output  1  registered flag; high when O == 0.

Function
REQ-013 Elaboration SHALL fail if MAX > 2**WIDTH-1, MAX < 1, or DIV < 1.
REQ-014 Per-edge priority SHALL be RESET > LOAD > CE step > hold.
REQ-015 The internal prescaler PS SHALL have ceil(log2(DIV)) bits (minimum 1), range 0..DIV-1.
REQ-016 With CE=1 and LOAD=0, PS SHALL advance by 1 per cycle; a "step" occurs on the cycle where PS == DIV-1, and PS returns to 0 on that cycle.
REQ-017 With DIV=1, every cycle with CE=1 SHALL be a step.
REQ-018 With CE=0, O and PS SHALL hold, and COUT SHALL be 0 on the next edge.
REQ-019 Up step: O <= O+1 if O < MAX; O <= 0 if O == MAX (wrap).
REQ-020 Down step: O <= O-1 if O > 0; O <= MAX if O == 0 (wrap).
REQ-021 UP SHALL be sampled only on step cycles; changing UP between steps SHALL not disturb PS.
REQ-022 COUT SHALL be 1 for exactly the cycle in which O first shows the wrapped value (0 for up, MAX for down), and 0 otherwise.
REQ-023 LOAD=1: O <= D if D <= MAX, else O <= MAX (saturate); PS <= 0; COUT <= 0, regardless of CE or UP.
REQ-024 ZERO SHALL be updated on the same edge as O and SHALL equal (next O == 0); it SHALL never lag O.
REQ-025 Arithmetic SHALL be performed modulo the range 0..MAX only; O SHALL never hold a value > MAX.
REQ-026 The latency from a step cycle to the updated O/COUT/ZERO SHALL be exactly 1 clock.

Reset
REQ-027 RESET=1 SHALL set O=0, PS=0, COUT=0, and ZERO=1 on the next edge, overriding LOAD and CE.
REQ-028 A reset mid-prescale or mid-count SHALL discard all partial progress; counting SHALL resume from PS=0 and O=0 on the first edge with RESET=0.
REQ-029 Outputs SHALL be defined only after the first reset edge; no power-up value is guaranteed.

Verification
REQ-030 Default parameters, CE=1, UP=1, 2**22 cycles after reset -> O=0 with COUT=1 at cycle 2**22, COUT=0 on all other cycles, O[21] toggles every 2**21 cycles.
REQ-031 WIDTH=4, MAX=9, DIV=3, UP=1, CE=1 from reset -> O increments every 3rd cycle, sequence 0..9,0, with COUT high only when O returns to 0 (cycle 30).
REQ-032 WIDTH=4, MAX=9, DIV=1, UP=0 from reset -> O sequence 9,8,...,0,9; COUT=1 on each transition to 9; ZERO=1 exactly when O=0.
REQ-033 WIDTH=4, MAX=9: LOAD=1 with D=12 while CE=1 -> O=9, COUT=0; then a single up step -> O=0 and COUT=1.
REQ-034 DIV=3: after 2 enabled cycles, apply LOAD (D=5) -> O=5 and PS cleared; the next step occurs 3 enabled cycles later; CE toggling 1,0,1,0,1 -> one step after the third enabled cycle.
REQ-035 RESET asserted together with LOAD=1 and CE=1 at O=MAX -> O=0, COUT=0, ZERO=1; on release, the first step occurs after DIV enabled cycles.
